// File: rtl/store_checker_if.sv
// -----------------------------------------------------------------------------
// store_checker_if
// Bundles the store_checker table-load port, run control, observed store port
// and result outputs.
//   slave  : seen by store_checker (loads/control/stores in, results out)
//   master : seen by the driver/testbench (loads/control/stores out, results in)
// Parameters must match those of the attached store_checker.
// -----------------------------------------------------------------------------
interface store_checker_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 25
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          busy;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [MW-1:0] match_cnt;
  logic [AW-1:0] fail_adr;
  logic [DW-1:0] fail_data;
  logic [CW-1:0] cycle_cnt;

  modport slave (
    input  ld_en, ld_idx, ld_adr, ld_data, start, MemWrite, DataAdr, WriteData,
    output busy, done, pass, fail_code, match_cnt, fail_adr, fail_data, cycle_cnt
  );

  modport master (
    output ld_en, ld_idx, ld_adr, ld_data, start, MemWrite, DataAdr, WriteData,
    input  busy, done, pass, fail_code, match_cnt, fail_adr, fail_data, cycle_cnt
  );
endinterface

// File: rtl/store_checker.sv
// -----------------------------------------------------------------------------
// store_checker
// Table-driven monitor of a data-memory write port. Observed stores are
// compared in order against a loadable table of expected (address, data)
// pairs; the run ends in PASS (all entries seen), FAIL (a non-matching store
// with STRICT=1) or TIMEOUT (cycle budget exhausted).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears state and outputs, not table)
//   bus   : store_checker_if.slave (load port, start, observed store, results)
// -----------------------------------------------------------------------------
module store_checker #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 25,
  parameter int STRICT  = 1
) (
  input  logic           clk,
  input  logic           reset,
  store_checker_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [1:0]    fail_code_q, fail_code_d;
  logic [AW-1:0] fail_adr_q, fail_adr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [AW-1:0] tbl_adr_q  [DEPTH];
  logic [DW-1:0] tbl_data_q [DEPTH];

  logic load_ok;
  logic store_hit;
  logic last_entry;

  // Loads are locked out during a run so the table under test stays stable.
  assign load_ok    = bus.ld_en && (state_q != ST_RUN) && (int'(bus.ld_idx) < DEPTH);
  assign store_hit  = bus.MemWrite && (bus.DataAdr == tbl_adr_q[ptr_q])
                      && (bus.WriteData == tbl_data_q[ptr_q]);
  assign last_entry = (ptr_q == IW'(DEPTH - 1));

  // Expected-store table; intentionally not reset so it survives a reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      tbl_adr_q[bus.ld_idx]  <= bus.ld_adr;
      tbl_data_q[bus.ld_idx] <= bus.ld_data;
    end
  end

  // Next-state and next-output logic for the run FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    match_cnt_d = match_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    fail_code_d = fail_code_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          ptr_d       = '0;
          match_cnt_d = '0;
          cycle_cnt_d = '0;
          fail_code_d = FC_NONE;
          fail_adr_d  = '0;
          fail_data_d = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CW'(1'b1);
        if (store_hit) begin
          ptr_d       = ptr_q + IW'(1'b1);
          match_cnt_d = match_cnt_q + MW'(1'b1);
        end else begin
          ptr_d = ptr_q;
        end
        // Priority: completing match, then mismatch, then cycle budget.
        if (store_hit && last_entry) begin
          state_d = ST_PASS;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (!store_hit && bus.MemWrite && (STRICT != 0)) begin
          state_d     = ST_FAIL;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_code_d = FC_MISMATCH;
          fail_adr_d  = bus.DataAdr;
          fail_data_d = bus.WriteData;
        end else if (cycle_cnt_d == CW'(TIMEOUT)) begin
          state_d     = ST_TIMEOUT;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_code_d = FC_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      match_cnt_q <= '0;
      cycle_cnt_q <= '0;
      fail_code_q <= FC_NONE;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      match_cnt_q <= match_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      fail_code_q <= fail_code_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = fail_code_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.fail_adr  = fail_adr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_store_checker.sv
// -----------------------------------------------------------------------------
// tb_store_checker
// Drives a strict (STRICT=1) and a lenient (STRICT=0) store_checker with the
// same stimulus and compares both against a behavioural model every cycle,
// plus hand-computed expectations at key points of the directed runs.
// -----------------------------------------------------------------------------
module tb_store_checker;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DEPTH   = 3;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_idx = 2'd0;
  logic [31:0] ld_adr = 32'd0;
  logic [31:0] ld_data = 32'd0;
  logic        start = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = 32'd0;
  logic [31:0] write_data = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_checker_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) if_s ();
  store_checker_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) if_l ();

  assign if_s.ld_en = ld_en;       assign if_l.ld_en = ld_en;
  assign if_s.ld_idx = ld_idx;     assign if_l.ld_idx = ld_idx;
  assign if_s.ld_adr = ld_adr;     assign if_l.ld_adr = ld_adr;
  assign if_s.ld_data = ld_data;   assign if_l.ld_data = ld_data;
  assign if_s.start = start;       assign if_l.start = start;
  assign if_s.MemWrite = mem_write;  assign if_l.MemWrite = mem_write;
  assign if_s.DataAdr = data_adr;    assign if_l.DataAdr = data_adr;
  assign if_s.WriteData = write_data; assign if_l.WriteData = write_data;

  store_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1)) u_strict (
    .clk(clk), .reset(reset_n), .bus(if_s.slave));
  store_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(0)) u_lenient (
    .clk(clk), .reset(reset_n), .bus(if_l.slave));

  // ---------------- behavioural model (index 0 strict, 1 lenient) ----------
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_pass [2];
  logic [1:0]  m_code [2];
  int          m_match[2];
  int          m_cyc  [2];
  logic [31:0] m_fadr [2];
  logic [31:0] m_fdata[2];
  logic [31:0] m_tadr [2][DEPTH];
  logic [31:0] m_tdata[2][DEPTH];
  bit          m_ld_ok;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0; m_code[i] = 2'd0;
      m_match[i] = 0; m_cyc[i] = 0; m_fadr[i] = 32'd0; m_fdata[i] = 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
        m_tadr[i][k] = 32'd0; m_tdata[i][k] = 32'd0;
      end
    end
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          m_run[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0; m_code[i] = 2'd0;
          m_match[i] = 0; m_cyc[i] = 0; m_fadr[i] = 32'd0; m_fdata[i] = 32'd0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          m_ld_ok = ld_en && !m_run[i] && (int'(ld_idx) < DEPTH);
          if (m_run[i]) begin
            m_cyc[i] = m_cyc[i] + 1;
            if (mem_write && data_adr == m_tadr[i][m_match[i]]
                && write_data == m_tdata[i][m_match[i]]) begin
              m_match[i] = m_match[i] + 1;
              if (m_match[i] == DEPTH) begin
                m_run[i] = 1'b0; m_done[i] = 1'b1; m_pass[i] = 1'b1;
              end
            end else if (mem_write && i == 0) begin
              m_run[i] = 1'b0; m_done[i] = 1'b1; m_code[i] = 2'b01;
              m_fadr[i] = data_adr; m_fdata[i] = write_data;
            end
            if (m_run[i] && m_cyc[i] == TIMEOUT) begin
              m_run[i] = 1'b0; m_done[i] = 1'b1; m_code[i] = 2'b10;
            end
          end else if (start) begin
            m_run[i] = 1'b1; m_done[i] = 1'b0; m_pass[i] = 1'b0; m_code[i] = 2'd0;
            m_match[i] = 0; m_cyc[i] = 0; m_fadr[i] = 32'd0; m_fdata[i] = 32'd0;
          end
          if (m_ld_ok) begin
            m_tadr[i][ld_idx]  = ld_adr;
            m_tdata[i][ld_idx] = ld_data;
          end
        end
      end
    end
  end

  // ---------------- comparison helper ----------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every falling edge: both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("s.busy", if_s.busy, m_run[0]);
      chk("s.done", if_s.done, m_done[0]);
      chk("s.pass", if_s.pass, m_pass[0]);
      chk("s.fail_code", if_s.fail_code, m_code[0]);
      chk("s.match_cnt", if_s.match_cnt, m_match[0]);
      chk("s.cycle_cnt", if_s.cycle_cnt, m_cyc[0]);
      chk("s.fail_adr", if_s.fail_adr, m_fadr[0]);
      chk("s.fail_data", if_s.fail_data, m_fdata[0]);
      chk("l.busy", if_l.busy, m_run[1]);
      chk("l.done", if_l.done, m_done[1]);
      chk("l.pass", if_l.pass, m_pass[1]);
      chk("l.fail_code", if_l.fail_code, m_code[1]);
      chk("l.match_cnt", if_l.match_cnt, m_match[1]);
      chk("l.cycle_cnt", if_l.cycle_cnt, m_cyc[1]);
      chk("l.fail_adr", if_l.fail_adr, m_fadr[1]);
      chk("l.fail_data", if_l.fail_data, m_fdata[1]);
    end
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic cyc(input bit st, input bit le, input int li, input int la, input int ld,
                     input bit mw, input int da, input int wd);
    start = st; ld_en = le; ld_idx = 2'(li); ld_adr = la; ld_data = ld;
    mem_write = mw; data_adr = da; write_data = wd;
    @(posedge clk);
    #1;
    start = 1'b0; ld_en = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic store(input int a, input int d);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, a, d);
  endtask

  task automatic load(input int i, input int a, input int d);
    cyc(1'b0, 1'b1, i, a, d, 1'b0, 0, 0);
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  // ---------------- directed + random sequence -------------------------------
  initial begin
    int idx;
    #2 reset_n = 1'b0;
    #1;
    chk("rst.s.busy", if_s.busy, 1'b0);
    chk("rst.s.done", if_s.done, 1'b0);
    chk("rst.l.match", if_l.match_cnt, 2'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    load(0, 96, 10); load(1, 100, 7); load(2, 104, 3); load(3, 999, 999);

    // full in-order pass with a gap
    go(); store(96, 10); idle(1); store(100, 7); store(104, 3);
    chk("A.s.pass", if_s.pass, 1'b1);
    chk("A.s.match", if_s.match_cnt, 2'd3);
    chk("A.s.cycle", if_s.cycle_cnt, 5'd4);
    chk("A.s.code", if_s.fail_code, 2'b00);

    // mismatch: strict fails, lenient ignores stray stores
    go(); store(96, 10); store(100, 8);
    chk("B.s.done", if_s.done, 1'b1);
    chk("B.s.code", if_s.fail_code, 2'b01);
    chk("B.s.fadr", if_s.fail_adr, 32'd100);
    chk("B.s.fdata", if_s.fail_data, 32'd8);
    chk("B.s.match", if_s.match_cnt, 2'd1);
    chk("B.l.busy", if_l.busy, 1'b1);
    store(84, 1); store(100, 7); store(104, 3);
    chk("B.l.pass", if_l.pass, 1'b1);
    chk("B.l.match", if_l.match_cnt, 2'd3);
    chk("B.l.fadr", if_l.fail_adr, 32'd0);
    chk("B.s.hold", if_s.fail_code, 2'b01);

    // timeout with no stores
    go(); idle(TIMEOUT - 1);
    chk("C.s.busy15", if_s.busy, 1'b1);
    idle(1);
    chk("C.s.done", if_s.done, 1'b1);
    chk("C.s.code", if_s.fail_code, 2'b10);
    chk("C.s.cycle", if_s.cycle_cnt, 5'd16);
    chk("C.s.busy", if_s.busy, 1'b0);

    // last match lands on the TIMEOUT-th edge: PASS wins
    go(); idle(TIMEOUT - 3); store(96, 10); store(100, 7); store(104, 3);
    chk("D.s.pass", if_s.pass, 1'b1);
    chk("D.s.code", if_s.fail_code, 2'b00);
    chk("D.s.cycle", if_s.cycle_cnt, 5'd16);

    // load together with start, then a load during RUN is ignored
    cyc(1'b1, 1'b1, 0, 200, 1, 1'b0, 0, 0);
    store(200, 1);
    cyc(1'b0, 1'b1, 1, 555, 5, 1'b1, 100, 7);
    chk("E.s.match", if_s.match_cnt, 2'd2);
    store(104, 3);
    chk("E.s.pass", if_s.pass, 1'b1);

    // asynchronous reset mid-run, then rerun on the retained table
    go(); store(200, 1);
    chk("R.s.pre", if_s.match_cnt, 2'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("R.s.busy", if_s.busy, 1'b0);
    chk("R.s.match", if_s.match_cnt, 2'd0);
    chk("R.s.cycle", if_s.cycle_cnt, 5'd0);
    chk("R.l.busy", if_l.busy, 1'b0);
    #4 reset_n = 1'b1;
    go(); store(200, 1); store(100, 7); store(104, 3);
    chk("R.s.pass", if_s.pass, 1'b1);
    chk("R.l.match", if_l.match_cnt, 2'd3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit st, le, mw;
      int li, la, ld, da, wd;
      st = ($urandom_range(0, 7) == 0);
      le = ($urandom_range(0, 7) == 0);
      li = $urandom_range(0, 3);
      la = 96 + 4 * $urandom_range(0, 3);
      ld = $urandom_range(0, 3);
      mw = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        idx = (m_match[1] < DEPTH) ? m_match[1] : 0;
        da = m_tadr[1][idx];
        wd = m_tdata[1][idx];
      end else begin
        da = 96 + 4 * $urandom_range(0, 3);
        wd = $urandom_range(0, 3);
      end
      cyc(st, le, li, la, ld, mw, da, wd);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset_n = 1'b0;
        #5 reset_n = 1'b1;
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
